// File: rtl/cmp_pipe_pkg.sv
// cmp_pipe_pkg: constants shared by the pipelined comparator.
//   MODE_*       3-bit compare mode encodings seen on the mode port.
//   FLAG_*       bit positions inside the 4-bit {N,Z,C,V} flags bus.
//   num_stages() pipeline depth (and latency in cycles) for a WIDTH/CHUNK pair.
package cmp_pipe_pkg;

    localparam logic [2:0] MODE_UGE = 3'd0;
    localparam logic [2:0] MODE_ULT = 3'd1;
    localparam logic [2:0] MODE_UGT = 3'd2;
    localparam logic [2:0] MODE_ULE = 3'd3;
    localparam logic [2:0] MODE_EQ  = 3'd4;
    localparam logic [2:0] MODE_NE  = 3'd5;
    localparam logic [2:0] MODE_SGE = 3'd6;
    localparam logic [2:0] MODE_SLT = 3'd7;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // WIDTH is expected to be an exact multiple of CHUNK.
    function automatic int num_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// cmp_chunk: combinational CHUNK-bit slice of the subtract chain, a + ~b + cin.
//   i_a, i_b  operand slices
//   i_cin     carry into the slice (1 for the lowest slice)
//   o_diff    difference bits of the slice
//   o_cout    carry out of the slice (1 = no borrow)
//   o_zero    1 when every difference bit of the slice is 0
module cmp_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_diff,
    output logic             o_cout,
    output logic             o_zero
);

    logic [CHUNK:0] w_sum;

    assign w_sum  = {1'b0, i_a} + {1'b0, ~i_b} + {{CHUNK{1'b0}}, i_cin};
    assign o_diff = w_sum[CHUNK-1:0];
    assign o_cout = w_sum[CHUNK];
    assign o_zero = ~|w_sum[CHUNK-1:0];

endmodule

// File: rtl/cmp_pipe.sv
// cmp_pipe: pipelined WIDTH-bit comparator with eight compare modes.
// I0 - I1 is evaluated CHUNK bits per stage; latency is WIDTH/CHUNK cycles.
//   CLK, RESET          clock; synchronous active-high reset
//   in_valid/in_ready   operand stream (I0, I1, mode)
//   out_valid/out_ready result stream (O, flags = {N,Z,C,V})
//
// Handshake: a beat moves on an edge where valid & ready are both 1. The
// whole pipeline advances together and only stalls when the last stage holds
// a result the consumer refuses, so in_ready mirrors that stall. Producers
// may raise valid without looking at ready; data must stay stable until the
// beat is taken.
module cmp_pipe
    import cmp_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             O,
    output logic [3:0]       flags
);

    localparam int STAGES = num_stages(WIDTH, CHUNK);
    localparam int LAST   = STAGES - 1;

    // Stage registers; index k holds the state after chunk k.
    // r_a/r_b keep the not-yet-consumed operand bits shifted down to bit 0;
    // r_d collects difference chunks from the top and ends fully aligned.
    logic             r_vld   [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic [WIDTH-1:0] r_d     [STAGES];
    logic             r_c     [STAGES];
    logic             r_z     [STAGES];
    logic             r_a_msb [STAGES];
    logic             r_b_msb [STAGES];
    logic [2:0]       r_m     [STAGES];

    logic             w_nxt_vld   [STAGES];
    logic [WIDTH-1:0] w_nxt_a     [STAGES];
    logic [WIDTH-1:0] w_nxt_b     [STAGES];
    logic [WIDTH-1:0] w_nxt_d     [STAGES];
    logic             w_nxt_c     [STAGES];
    logic             w_nxt_z     [STAGES];
    logic             w_nxt_a_msb [STAGES];
    logic             w_nxt_b_msb [STAGES];
    logic [2:0]       w_nxt_m     [STAGES];

    logic w_adv;

    assign out_valid = r_vld[LAST];
    assign w_adv     = ~(out_valid & ~out_ready);
    // Reset empties the pipe, so the input side is ready while it is held.
    assign in_ready  = w_adv | RESET;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             w_src_vld;
        logic [WIDTH-1:0] w_src_a;
        logic [WIDTH-1:0] w_src_b;
        logic [WIDTH-1:0] w_src_d;
        logic             w_src_c;
        logic             w_src_z;
        logic             w_src_a_msb;
        logic             w_src_b_msb;
        logic [2:0]       w_src_m;
        logic [CHUNK-1:0] w_dch;
        logic             w_cout;
        logic             w_zch;

        if (k == 0) begin : g_first
            // Subtraction as I0 + ~I1 + 1: the lowest carry-in is a constant 1.
            assign w_src_vld   = in_valid;
            assign w_src_a     = I0;
            assign w_src_b     = I1;
            assign w_src_d     = '0;
            assign w_src_c     = 1'b1;
            assign w_src_z     = 1'b1;
            assign w_src_a_msb = I0[WIDTH-1];
            assign w_src_b_msb = I1[WIDTH-1];
            assign w_src_m     = mode;
        end else begin : g_next
            assign w_src_vld   = r_vld[k-1];
            assign w_src_a     = r_a[k-1];
            assign w_src_b     = r_b[k-1];
            assign w_src_d     = r_d[k-1];
            assign w_src_c     = r_c[k-1];
            assign w_src_z     = r_z[k-1];
            assign w_src_a_msb = r_a_msb[k-1];
            assign w_src_b_msb = r_b_msb[k-1];
            assign w_src_m     = r_m[k-1];
        end

        cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
            .i_a    (w_src_a[CHUNK-1:0]),
            .i_b    (w_src_b[CHUNK-1:0]),
            .i_cin  (w_src_c),
            .o_diff (w_dch),
            .o_cout (w_cout),
            .o_zero (w_zch)
        );

        assign w_nxt_vld[k]   = w_src_vld;
        assign w_nxt_a[k]     = w_src_a >> CHUNK;
        assign w_nxt_b[k]     = w_src_b >> CHUNK;
        assign w_nxt_d[k]     = (w_src_d >> CHUNK) | (WIDTH'(w_dch) << (WIDTH - CHUNK));
        assign w_nxt_c[k]     = w_cout;
        assign w_nxt_z[k]     = w_src_z & w_zch;
        assign w_nxt_a_msb[k] = w_src_a_msb;
        assign w_nxt_b_msb[k] = w_src_b_msb;
        assign w_nxt_m[k]     = w_src_m;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k]   <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_d[k]     <= '0;
                r_c[k]     <= 1'b0;
                r_z[k]     <= 1'b0;
                r_a_msb[k] <= 1'b0;
                r_b_msb[k] <= 1'b0;
                r_m[k]     <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k]   <= w_nxt_vld[k];
                r_a[k]     <= w_nxt_a[k];
                r_b[k]     <= w_nxt_b[k];
                r_d[k]     <= w_nxt_d[k];
                r_c[k]     <= w_nxt_c[k];
                r_z[k]     <= w_nxt_z[k];
                r_a_msb[k] <= w_nxt_a_msb[k];
                r_b_msb[k] <= w_nxt_b_msb[k];
                r_m[k]     <= w_nxt_m[k];
            end
        end
    end

    // Decode from the last stage only; holding that stage keeps O/flags steady.
    logic w_n, w_z, w_c, w_v;

    always_comb begin
        w_n = r_d[LAST][WIDTH-1];
        w_z = r_z[LAST];
        w_c = r_c[LAST];
        // Signed overflow: operand signs differ and the result sign left I0's.
        w_v = (r_a_msb[LAST] != r_b_msb[LAST]) & (r_d[LAST][WIDTH-1] != r_a_msb[LAST]);

        flags         = '0;
        flags[FLAG_N] = w_n;
        flags[FLAG_Z] = w_z;
        flags[FLAG_C] = w_c;
        flags[FLAG_V] = w_v;

        O = 1'b0;
        case (r_m[LAST])
            MODE_UGE: O = w_c;
            MODE_ULT: O = ~w_c;
            MODE_UGT: O = w_c & ~w_z;
            MODE_ULE: O = ~w_c | w_z;
            MODE_EQ:  O = w_z;
            MODE_NE:  O = ~w_z;
            MODE_SGE: O = (w_n == w_v);
            MODE_SLT: O = (w_n != w_v);
            default:  O = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cmp_pipe.sv
// tb_cmp_pipe: self-checking bench for cmp_pipe with WIDTH=8, CHUNK=2.
module tb_cmp_pipe;

    localparam int W      = 8;
    localparam int STAGES = 4;

    logic         CLK;
    logic         RESET;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] I0;
    logic [W-1:0] I1;
    logic [2:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic         O;
    logic [3:0]   flags;

    cmp_pipe #(.WIDTH(W), .CHUNK(2)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .I0        (I0),
        .I1        (I1),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .O         (O),
        .flags     (flags)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [4:0] exp_q[$];   // {O, N, Z, C, V}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model straight from the compare definitions.
    function automatic logic [4:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] m);
        int sa, sb, sd;
        logic [W-1:0] d;
        logic n, z, c, v, o;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sd = sa - sb;
        d  = a - b;
        n  = d[W-1];
        z  = (a == b);
        c  = (a >= b);
        v  = (sd > 127) || (sd < -128);
        case (m)
            3'd0:    o = (a >= b);
            3'd1:    o = (a < b);
            3'd2:    o = (a > b);
            3'd3:    o = (a <= b);
            3'd4:    o = (a == b);
            3'd5:    o = (a != b);
            3'd6:    o = (sa >= sb);
            default: o = (sa < sb);
        endcase
        return {o, n, z, c, v};
    endfunction

    logic lat_arm     = 1'b0;
    int   lat_out_cyc = -1;
    logic rand_bp     = 1'b0;

    always @(negedge CLK) begin
        logic [4:0] e;
        if (!RESET && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("beat_o", 32'(O), 32'(e[4]));
                check("beat_flags", 32'(flags), 32'(e[3:0]));
            end
        end
        if (lat_arm && out_valid) begin
            lat_out_cyc = cyc;
            lat_arm     = 1'b0;
        end
    end

    always @(posedge CLK) begin
        if (rand_bp) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks (start/end just after a rising edge) ----------------
    int last_acc_cyc = 0;

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] m,
                        input logic [4:0] e);
        int guard;
        in_valid = 1'b1;
        I0       = a;
        I1       = b;
        mode     = m;
        guard    = 0;
        @(negedge CLK);
        while (!in_ready && guard < 200) begin
            guard++;
            @(negedge CLK);
        end
        check("accept", 32'(in_ready), 32'd1);
        last_acc_cyc = cyc;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [W-1:0] a, b;
        logic [2:0]   m;
        a = W'($urandom);
        b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
        m = 3'($urandom_range(0, 7));
        send(a, b, m, model(a, b, m));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            guard++;
            @(posedge CLK);
        end
        repeat (STAGES + 2) @(posedge CLK);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   m;
        logic         o;
        logic [3:0]   f;   // {N,Z,C,V}
    } vec_t;

    vec_t tbl[9];

    initial begin
        int lat_acc;
        int seen;

        tbl[0] = '{8'h80, 8'h7F, 3'd0, 1'b1, 4'b0011};  // UGE
        tbl[1] = '{8'h80, 8'h7F, 3'd6, 1'b0, 4'b0011};  // SGE: -128 < 127
        tbl[2] = '{8'h5A, 8'h5A, 3'd4, 1'b1, 4'b0110};  // EQ
        tbl[3] = '{8'h5A, 8'h5A, 3'd2, 1'b0, 4'b0110};  // UGT
        tbl[4] = '{8'h5A, 8'h5A, 3'd3, 1'b1, 4'b0110};  // ULE
        tbl[5] = '{8'h00, 8'hFF, 3'd1, 1'b1, 4'b0000};  // ULT
        tbl[6] = '{8'hFF, 8'h00, 3'd7, 1'b1, 4'b1010};  // SLT: -1 < 0
        tbl[7] = '{8'hFF, 8'h00, 3'd0, 1'b1, 4'b1010};  // UGE
        tbl[8] = '{8'h7F, 8'h80, 3'd7, 1'b0, 4'b1001};  // SLT: 127 > -128

        RESET     = 1'b1;
        in_valid  = 1'b0;
        I0        = '0;
        I1        = '0;
        mode      = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("ready_in_reset", 32'(in_ready), 32'd1);
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_o", 32'(O), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge CLK);
        #1;

        // Directed table, streamed back to back
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].m, {tbl[i].o, tbl[i].f});
        end
        drain();

        // 16 random beats, out_ready held high; first-result latency
        lat_arm = 1'b1;
        lat_acc = 0;
        for (int i = 0; i < 16; i++) begin
            send_rand();
            if (i == 0) lat_acc = last_acc_cyc;
        end
        drain();
        check("latency_stream", 32'(lat_out_cyc - lat_acc), 32'(STAGES));

        // Fill with consumer stalled, hold 3 cycles, release
        out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) send_rand();
        repeat (3) begin
            @(negedge CLK);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_o", 32'(O), 32'(exp_q[0][4]));
            check("stall_flags", 32'(flags), 32'(exp_q[0][3:0]));
            @(posedge CLK);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // Random backpressure and random input gaps
        rand_bp = 1'b1;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK);
                #1;
            end
            send_rand();
        end
        rand_bp = 1'b0;
        @(posedge CLK);
        #2 out_ready = 1'b1;
        drain();

        // Reset with beats in flight
        for (int i = 0; i < 3; i++) send_rand();
        RESET = 1'b1;
        @(negedge CLK);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge CLK);
        #1 RESET = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_o", 32'(O), 32'd0);
        check("post_rst_flags", 32'(flags), 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge CLK);
            if (out_valid) seen++;
        end
        check("flushed_beats", 32'(seen), 32'd0);
        @(posedge CLK);
        #1;
        lat_arm = 1'b1;
        send(8'h12, 8'h34, 3'd3, model(8'h12, 8'h34, 3'd3));
        lat_acc = last_acc_cyc;
        drain();
        check("latency_after_rst", 32'(lat_out_cyc - lat_acc), 32'(STAGES));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
